// File: rtl/register_file.sv
// Architectural integer register file with combinational operand reads, an
// immediate write port, and a pending-write scoreboard for late load results.
package register_file_pkg;
    typedef struct packed {
        logic [4:0] rs1Address;
        logic [4:0] rs2Address;
        logic [4:0] rdAddress;
    } DecodedAddresses;
endpackage

module register_file
    import register_file_pkg::*;
#(
    parameter int unsigned XLEN            = 32,
    parameter int unsigned MAX_OUTSTANDING = 1
) (
    input  logic            clock,
    input  logic            reset,
    input  DecodedAddresses decodedAddresses,
    input  logic            issueValid,
    output logic            issueReady,
    input  logic            rdWriteNow,
    input  logic [XLEN-1:0] rdDataNow,
    input  logic            rdWriteLater,
    input  logic            loadDone,
    input  logic [4:0]      loadAddress,
    input  logic [XLEN-1:0] loadData,
    output logic [XLEN-1:0] rs1Data,
    output logic [XLEN-1:0] rs2Data,
    output logic [31:0]     pendingMask
);

    localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

    logic [XLEN-1:0] regs [32];
    logic [31:0]     pending;
    logic [CW-1:0]   outstanding;

    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] load_onehot;
    logic [31:0] pend_eff;
    logic        full;
    logic        fire;
    logic        set_pend;
    logic        clr_pend;
    logic        write_now;

    assign rs1 = decodedAddresses.rs1Address;
    assign rs2 = decodedAddresses.rs2Address;
    assign rd  = decodedAddresses.rdAddress;

    // A register being written back this cycle no longer counts as pending,
    // which lets the dependent instruction issue in the same cycle.
    assign load_onehot = loadDone ? (32'd1 << loadAddress) : '0;
    assign pend_eff    = pending & ~load_onehot;
    assign full        = (outstanding == MAX_CNT);

    assign issueReady = !pend_eff[rs1] && !pend_eff[rs2] && !pend_eff[rd]
                        && !(rdWriteLater && (rd != '0) && full && !loadDone);

    assign fire      = issueValid && issueReady;
    assign set_pend  = fire && rdWriteLater && (rd != '0);
    assign write_now = fire && !rdWriteLater && rdWriteNow && (rd != '0);
    assign clr_pend  = loadDone && pending[loadAddress];

    assign pendingMask = pending;

    always_comb begin
        rs1Data = '0;
        if (rs1 == '0)
            rs1Data = '0;
        else if (loadDone && (loadAddress == rs1))
            rs1Data = loadData;
        else
            rs1Data = regs[rs1];
    end

    always_comb begin
        rs2Data = '0;
        if (rs2 == '0)
            rs2Data = '0;
        else if (loadDone && (loadAddress == rs2))
            rs2Data = loadData;
        else
            rs2Data = regs[rs2];
    end

    // Later assignments take precedence: issue write beats load writeback,
    // and a new pending set beats a same-cycle clear.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < 32; i++)
                regs[i] <= '0;
            pending     <= '0;
            outstanding <= '0;
        end else begin
            if (loadDone && (loadAddress != '0))
                regs[loadAddress] <= loadData;
            if (write_now)
                regs[rd] <= rdDataNow;
            if (loadDone)
                pending[loadAddress] <= 1'b0;
            if (set_pend)
                pending[rd] <= 1'b1;
            if (clr_pend && !set_pend && (outstanding != '0))
                outstanding <= outstanding - CW'(1);
            else if (set_pend && !clr_pend && !full)
                outstanding <= outstanding + CW'(1);
        end
    end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed scenarios plus randomized
// traffic compared against an array-based reference model.
module tb_register_file;
    import register_file_pkg::*;

    localparam int unsigned XLEN = 32;
    localparam int MAXO = 1;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    DecodedAddresses decodedAddresses;
    logic            issueValid;
    logic            issueReady;
    logic            rdWriteNow;
    logic [XLEN-1:0] rdDataNow;
    logic            rdWriteLater;
    logic            loadDone;
    logic [4:0]      loadAddress;
    logic [XLEN-1:0] loadData;
    logic [XLEN-1:0] rs1Data;
    logic [XLEN-1:0] rs2Data;
    logic [31:0]     pendingMask;

    int vectors = 0;
    int miscompares = 0;

    logic [XLEN-1:0] m_regs [32];
    bit              m_pend [32];
    int              m_count;

    register_file #(.XLEN(XLEN), .MAX_OUTSTANDING(MAXO)) dut (
        .clock(clock), .reset(reset), .decodedAddresses(decodedAddresses),
        .issueValid(issueValid), .issueReady(issueReady),
        .rdWriteNow(rdWriteNow), .rdDataNow(rdDataNow), .rdWriteLater(rdWriteLater),
        .loadDone(loadDone), .loadAddress(loadAddress), .loadData(loadData),
        .rs1Data(rs1Data), .rs2Data(rs2Data), .pendingMask(pendingMask)
    );

    always #5 clock = ~clock;

    task automatic m_reset();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = '0;
            m_pend[i] = 1'b0;
        end
        m_count = 0;
    endtask

    function automatic bit m_busy(input logic [4:0] a);
        return m_pend[a] && !(loadDone && loadAddress == a);
    endfunction

    function automatic bit m_ready();
        logic [4:0] s1, s2, d;
        s1 = decodedAddresses.rs1Address;
        s2 = decodedAddresses.rs2Address;
        d  = decodedAddresses.rdAddress;
        if (m_busy(s1) || m_busy(s2) || m_busy(d)) return 1'b0;
        if (rdWriteLater && d != 0 && m_count == MAXO && !loadDone) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [XLEN-1:0] m_read(input logic [4:0] a);
        if (a == 0) return '0;
        if (loadDone && loadAddress == a) return loadData;
        return m_regs[a];
    endfunction

    function automatic logic [31:0] m_mask();
        logic [31:0] m;
        for (int i = 0; i < 32; i++) m[i] = m_pend[i];
        return m;
    endfunction

    // Advance the model by one clock using the currently driven inputs.
    task automatic m_clock();
        bit fire;
        int delta;
        logic [4:0] d;
        d = decodedAddresses.rdAddress;
        fire = issueValid && m_ready();
        delta = 0;
        if (loadDone) begin
            if (loadAddress != 0) m_regs[loadAddress] = loadData;
            if (m_pend[loadAddress]) begin
                m_pend[loadAddress] = 1'b0;
                delta = delta - 1;
            end
        end
        if (fire) begin
            if (rdWriteLater && d != 0) begin
                m_pend[d] = 1'b1;
                delta = delta + 1;
            end else if (rdWriteNow && d != 0) begin
                m_regs[d] = rdDataNow;
            end
        end
        m_count = m_count + delta;
        if (m_count < 0) m_count = 0;
        if (m_count > MAXO) m_count = MAXO;
    endtask

    task automatic drive(input bit v, input int a1, input int a2, input int ad,
                         input bit wn, input logic [XLEN-1:0] dn, input bit wl,
                         input bit ldn, input int la, input logic [XLEN-1:0] ldat);
        issueValid = v;
        decodedAddresses.rs1Address = 5'(a1);
        decodedAddresses.rs2Address = 5'(a2);
        decodedAddresses.rdAddress  = 5'(ad);
        rdWriteNow = wn;
        rdDataNow = dn;
        rdWriteLater = wl;
        loadDone = ldn;
        loadAddress = 5'(la);
        loadData = ldat;
        #2;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, '0, 0, 0, 0, '0);
    endtask

    task automatic tick();
        m_clock();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        m_reset();
        idle();
        vectors++; if (issueReady !== 1'b1) begin miscompares++; $display("FAIL reset_ready got %b want 1", issueReady); end
        vectors++; if (pendingMask !== 32'h0) begin miscompares++; $display("FAIL reset_mask got %h want 0", pendingMask); end
        drive(0, 3, 4, 0, 0, '0, 0, 1, 3, 32'h99);
        vectors++; if (rs1Data !== 32'h99) begin miscompares++; $display("FAIL reset_bypass got %h want 99", rs1Data); end
        vectors++; if (rs2Data !== 32'h0) begin miscompares++; $display("FAIL reset_rs2 got %h want 0", rs2Data); end
        idle();
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic test_immediate();
        drive(1, 0, 0, 5, 1, 32'hDEADBEEF, 0, 0, 0, '0);
        vectors++; if (issueReady !== 1'b1) begin miscompares++; $display("FAIL imm_ready got %b want 1", issueReady); end
        tick();
        drive(1, 5, 0, 0, 1, 32'h1234, 0, 0, 0, '0);
        vectors++; if (rs1Data !== 32'hDEADBEEF) begin miscompares++; $display("FAIL imm_rs1 got %h want deadbeef", rs1Data); end
        vectors++; if (rs2Data !== 32'h0) begin miscompares++; $display("FAIL imm_rs2_x0 got %h want 0", rs2Data); end
        tick();
        drive(0, 0, 5, 0, 0, '0, 0, 0, 0, '0);
        vectors++; if (rs1Data !== 32'h0) begin miscompares++; $display("FAIL x0_write got %h want 0", rs1Data); end
        vectors++; if (rs2Data !== 32'hDEADBEEF) begin miscompares++; $display("FAIL imm_keep got %h want deadbeef", rs2Data); end
        tick();
    endtask

    task automatic test_late_stall();
        drive(1, 0, 0, 7, 0, '0, 1, 0, 0, '0);
        tick();
        idle();
        vectors++; if (pendingMask !== 32'h80) begin miscompares++; $display("FAIL late_mask got %h want 80", pendingMask); end
        for (int c = 0; c < 3; c++) begin
            drive(1, 0, 7, 8, 1, 32'h11, 0, 0, 0, '0);
            vectors++; if (issueReady !== 1'b0) begin miscompares++; $display("FAIL late_stall c%0d got %b want 0", c, issueReady); end
            tick();
        end
        drive(1, 0, 7, 8, 1, 32'h11, 0, 1, 7, 32'h55);
        vectors++; if (issueReady !== 1'b1) begin miscompares++; $display("FAIL late_release got %b want 1", issueReady); end
        vectors++; if (rs2Data !== 32'h55) begin miscompares++; $display("FAIL late_bypass got %h want 55", rs2Data); end
        tick();
        drive(0, 7, 8, 0, 0, '0, 0, 0, 0, '0);
        vectors++; if (pendingMask !== 32'h0) begin miscompares++; $display("FAIL late_clear got %h want 0", pendingMask); end
        vectors++; if (rs1Data !== 32'h55) begin miscompares++; $display("FAIL late_reg got %h want 55", rs1Data); end
        vectors++; if (rs2Data !== 32'h11) begin miscompares++; $display("FAIL late_dep_write got %h want 11", rs2Data); end
        tick();
    endtask

    task automatic test_max_outstanding();
        drive(1, 0, 0, 3, 0, '0, 1, 0, 0, '0);
        tick();
        for (int c = 0; c < 2; c++) begin
            drive(1, 0, 0, 4, 0, '0, 1, 0, 0, '0);
            vectors++; if (issueReady !== 1'b0) begin miscompares++; $display("FAIL max_stall c%0d got %b want 0", c, issueReady); end
            tick();
        end
        drive(1, 0, 0, 4, 0, '0, 1, 1, 3, 32'h33);
        vectors++; if (issueReady !== 1'b1) begin miscompares++; $display("FAIL max_release got %b want 1", issueReady); end
        tick();
        idle();
        vectors++; if (pendingMask !== 32'h10) begin miscompares++; $display("FAIL max_mask got %h want 10", pendingMask); end
        drive(0, 0, 0, 0, 0, '0, 0, 1, 4, 32'h44);
        tick();
        idle();
        vectors++; if (pendingMask !== 32'h0) begin miscompares++; $display("FAIL max_drain got %h want 0", pendingMask); end
    endtask

    task automatic test_waw();
        drive(1, 0, 0, 9, 0, '0, 1, 0, 0, '0);
        tick();
        for (int c = 0; c < 2; c++) begin
            drive(1, 0, 0, 9, 1, 32'hB, 0, 0, 0, '0);
            vectors++; if (issueReady !== 1'b0) begin miscompares++; $display("FAIL waw_stall c%0d got %b want 0", c, issueReady); end
            tick();
        end
        drive(1, 9, 0, 9, 1, 32'hB, 0, 1, 9, 32'hA);
        vectors++; if (issueReady !== 1'b1) begin miscompares++; $display("FAIL waw_release got %b want 1", issueReady); end
        vectors++; if (rs1Data !== 32'hA) begin miscompares++; $display("FAIL waw_bypass got %h want a", rs1Data); end
        tick();
        drive(0, 9, 0, 0, 0, '0, 0, 0, 0, '0);
        vectors++; if (rs1Data !== 32'hB) begin miscompares++; $display("FAIL waw_final got %h want b", rs1Data); end
        vectors++; if (pendingMask !== 32'h0) begin miscompares++; $display("FAIL waw_mask got %h want 0", pendingMask); end
        tick();
    endtask

    task automatic test_collision();
        drive(1, 0, 0, 12, 1, 32'h2, 0, 1, 12, 32'h1);
        vectors++; if (issueReady !== 1'b1) begin miscompares++; $display("FAIL col_ready got %b want 1", issueReady); end
        tick();
        drive(1, 12, 0, 13, 0, '0, 1, 0, 0, '0);
        vectors++; if (rs1Data !== 32'h2) begin miscompares++; $display("FAIL col_winner got %h want 2", rs1Data); end
        vectors++; if (issueReady !== 1'b1) begin miscompares++; $display("FAIL col_count got %b want 1", issueReady); end
        tick();
        drive(1, 0, 0, 14, 0, '0, 1, 0, 0, '0);
        vectors++; if (issueReady !== 1'b0) begin miscompares++; $display("FAIL col_full got %b want 0", issueReady); end
        idle();
        drive(0, 0, 0, 0, 0, '0, 0, 1, 13, 32'h13);
        tick();
    endtask

    task automatic test_reset_midload();
        drive(1, 0, 0, 6, 1, 32'h77, 0, 0, 0, '0);
        tick();
        drive(1, 0, 0, 6, 0, '0, 1, 0, 0, '0);
        tick();
        drive(1, 6, 0, 7, 0, '0, 1, 0, 0, '0);
        vectors++; if (pendingMask !== 32'h40) begin miscompares++; $display("FAIL mid_mask got %h want 40", pendingMask); end
        vectors++; if (rs1Data !== 32'h77) begin miscompares++; $display("FAIL mid_before got %h want 77", rs1Data); end
        reset = 1'b0;
        m_reset();
        #1;
        vectors++; if (pendingMask !== 32'h0) begin miscompares++; $display("FAIL mid_rst_mask got %h want 0", pendingMask); end
        vectors++; if (rs1Data !== 32'h0) begin miscompares++; $display("FAIL mid_rst_x6 got %h want 0", rs1Data); end
        vectors++; if (issueReady !== 1'b1) begin miscompares++; $display("FAIL mid_rst_ready got %b want 1", issueReady); end
        idle();
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        drive(0, 0, 0, 0, 0, '0, 0, 1, 6, 32'h5);
        tick();
        drive(1, 6, 0, 2, 0, '0, 1, 0, 0, '0);
        vectors++; if (rs1Data !== 32'h5) begin miscompares++; $display("FAIL stray_write got %h want 5", rs1Data); end
        vectors++; if (issueReady !== 1'b1) begin miscompares++; $display("FAIL stray_count got %b want 1", issueReady); end
        tick();
        drive(0, 0, 0, 0, 0, '0, 0, 1, 2, 32'h22);
        tick();
    endtask

    task automatic test_random();
        int q[$];
        int la;
        for (int n = 0; n < 400; n++) begin
            q.delete();
            for (int i = 1; i < 32; i++) if (m_pend[i]) q.push_back(i);
            la = $urandom_range(0, 7);
            if (q.size() > 0 && $urandom_range(0, 3) != 0) la = q[$urandom_range(0, q.size() - 1)];
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 7), $urandom_range(0, 1) == 1, $urandom(),
                  $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, la, $urandom());
            vectors++; if (issueReady !== m_ready()) begin miscompares++; $display("FAIL rnd_ready n%0d got %b want %b", n, issueReady, m_ready()); end
            vectors++; if (rs1Data !== m_read(decodedAddresses.rs1Address)) begin miscompares++; $display("FAIL rnd_rs1 n%0d got %h want %h", n, rs1Data, m_read(decodedAddresses.rs1Address)); end
            vectors++; if (rs2Data !== m_read(decodedAddresses.rs2Address)) begin miscompares++; $display("FAIL rnd_rs2 n%0d got %h want %h", n, rs2Data, m_read(decodedAddresses.rs2Address)); end
            vectors++; if (pendingMask !== m_mask()) begin miscompares++; $display("FAIL rnd_mask n%0d got %h want %h", n, pendingMask, m_mask()); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_immediate();
        test_late_stall();
        test_max_outstanding();
        test_waw();
        test_collision();
        test_reset_midload();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
